fpu_op_sequencer: RTL and testbench

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_op_sequencer.sv | 143 ++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU op sequencer: op codes, status codes, the
// quiet-NaN result used on abort, and the sequencer state enum.
package fpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/fpu_op_sequencer.sv
// Issues one FPU op at a time to a bank of functional units, waits (with a
// saturating timeout) for completion and holds the result until taken.
//
// state   | meaning
// IDLE    | ready for a request; illegal ops go straight to HOLD with a NaN
// START   | one-cycle start pulse to the selected unit, timeout cleared
// WAIT    | unit enabled, counting cycles until unit_done or TIMEOUT
// HOLD    | result/status presented until downstream accepts
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [4:0]  unit_en,
  output logic        unit_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [1:0]  status
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   result_q, result_d;
  logic [1:0]    status_q, status_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    op_onehot;
  logic          op_legal;

  assign op_legal = (op <= OP_SQRT);

  always_comb begin
    op_onehot = '0;
    case (op_q)
      OP_ADD:  op_onehot = 5'b00001;
      OP_SUB:  op_onehot = 5'b00010;
      OP_MUL:  op_onehot = 5'b00100;
      OP_DIV:  op_onehot = 5'b01000;
      OP_SQRT: op_onehot = 5'b10000;
      default: op_onehot = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    unit_start = 1'b0;
    unit_en    = '0;
    out_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op_legal) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            state_d = S_START;
          end else begin
            result_d = QNAN;
            status_d = ST_ILLEGAL;
            state_d  = S_HOLD;
          end
        end
      end
      S_START: begin
        unit_start = 1'b1;
        unit_en    = op_onehot;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        unit_en = op_onehot;
        // completion is checked first so a done on the timeout cycle still succeeds
        if (unit_done) begin
          result_d = unit_result;
          status_d = ST_OK;
          state_d  = S_HOLD;
        end else if (cnt_q == CNT_MAX) begin
          result_d = QNAN;
          status_d = ST_TIMEOUT;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign unit_a = a_q;
  assign unit_b = b_q;
  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: directed vector table, reset and
// backpressure sequences, then random ops against a latency/result model.
module tb_fpu_op_sequencer;

  localparam int TIMEOUT = 63;
  localparam logic [31:0] NAN_C = 32'h7FC0_0000;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  unit_en;
  logic        unit_start;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_done = 1'b0;
  logic [31:0] unit_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .unit_en(unit_en), .unit_start(unit_start),
    .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
    .unit_result(unit_result), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ures;
    int          delay;
    int          bp;
    bit          hold_req;
    int          lat;
    logic [31:0] res;
    logic [1:0]  st;
    logic [4:0]  en;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outcome of one op from first principles: a unit that finishes d cycles
  // after its start pulse is accepted as long as d <= TIMEOUT+1.
  task automatic model(input logic [2:0] m_op, input int d, input logic [31:0] ur,
                       output int lat, output logic [31:0] res,
                       output logic [1:0] st, output logic [4:0] en);
    if (m_op > 3'd4) begin
      lat = 1; res = NAN_C; st = 2'b01; en = 5'b0;
    end else begin
      en = 5'(1 << m_op);
      if (d <= TIMEOUT + 1) begin
        lat = d + 2; res = ur; st = 2'b00;
      end else begin
        lat = TIMEOUT + 3; res = NAN_C; st = 2'b10;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] v_op,
                        input logic [31:0] v_a, input logic [31:0] v_b,
                        input logic [31:0] v_ures, input int v_delay,
                        input int v_bp, input bit v_hold_req, input int v_lat,
                        input logic [31:0] v_res, input logic [1:0] v_st,
                        input logic [4:0] v_en);
    int starts, busy_bad, t, lat, hbad;
    bit got;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = v_op; a = v_a; b = v_b;
    starts = 0; busy_bad = 0; t = -1; lat = -1; got = 1'b0;
    for (int cyc = 1; cyc <= TIMEOUT + 10 && !got; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      unit_done = 1'b0;
      if (out_valid) begin
        got = 1'b1; lat = cyc;
      end else if (unit_en !== v_en || in_ready) begin
        busy_bad++;
      end
      if (unit_start) begin
        starts++; t = 0;
      end else if (t >= 0) begin
        t++;
      end
      if (t == v_delay) begin
        unit_done = 1'b1; unit_result = v_ures;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(v_lat));
    chk({tag, ".result"}, result, v_res);
    chk({tag, ".status"}, 32'(status), 32'(v_st));
    chk({tag, ".hold_en"}, 32'(unit_en), 32'd0);
    chk({tag, ".starts"}, 32'(starts), (v_en != 0) ? 32'd1 : 32'd0);
    chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
    if (v_en != 0) begin
      chk({tag, ".unit_a"}, unit_a, v_a);
      chk({tag, ".unit_b"}, unit_b, v_b);
    end
    hbad = 0;
    in_valid = v_hold_req; op = 3'd0;
    for (int i = 0; i < v_bp; i++) begin
      @(negedge clk);
      unit_done = 1'b0;
      if (!out_valid || result !== v_res || status !== v_st || in_ready || unit_start)
        hbad++;
    end
    if (v_bp > 0) chk({tag, ".hold_stable"}, 32'(hbad), 32'd0);
    in_valid = 1'b0; unit_done = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int lat_e, bad;
    logic [31:0] res_e, ur;
    logic [1:0] st_e;
    logic [4:0] en_e;
    logic [2:0] rop;
    int rd;

    vecs[0] = '{3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 2,     0,  1'b0, 4,  32'h40400000, 2'b00, 5'b00001};
    vecs[1] = '{3'd6, 32'h11111111, 32'h22222222, 32'h0,        1,     0,  1'b0, 1,  NAN_C,        2'b01, 5'b00000};
    vecs[2] = '{3'd3, 32'h40800000, 32'h40000000, 32'h0,        NEVER, 0,  1'b0, 66, NAN_C,        2'b10, 5'b01000};
    vecs[3] = '{3'd1, 32'h3F800000, 32'h40C00000, 32'hC0A00000, 1,     10, 1'b1, 3,  32'hC0A00000, 2'b00, 5'b00010};
    vecs[4] = '{3'd2, 32'h40000000, 32'h40A00000, 32'h41200000, 64,    2,  1'b0, 66, 32'h41200000, 2'b00, 5'b00100};
    vecs[5] = '{3'd2, 32'h40000000, 32'h40A00000, 32'h41200000, 65,    1,  1'b0, 66, NAN_C,        2'b10, 5'b00100};
    vecs[6] = '{3'd5, 32'hAAAAAAAA, 32'h55555555, 32'h0,        1,     0,  1'b0, 1,  NAN_C,        2'b01, 5'b00000};
    vecs[7] = '{3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1,     3,  1'b0, 1,  NAN_C,        2'b01, 5'b00000};
    vecs[8] = '{3'd4, 32'h41100000, 32'h0,        32'h40400000, 5,     0,  1'b0, 7,  32'h40400000, 2'b00, 5'b10000};

    repeat (3) @(negedge clk);
    chk("reset.ctrl", {22'd0, in_ready, out_valid, unit_start, unit_en, status}, 32'b10_0000_0000);
    chk("reset.result", result, 32'd0);
    chk("reset.unit_a", unit_a, 32'd0);
    chk("reset.unit_b", unit_b, 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (unit_start || out_valid || !in_ready) bad++;
    end
    chk("reset.quiet", 32'(bad), 32'd0);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ures,
             vecs[i].delay, vecs[i].bp, vecs[i].hold_req, vecs[i].lat,
             vecs[i].res, vecs[i].st, vecs[i].en);

    // Reset pulse in the middle of a mul that is still waiting
    @(negedge clk);
    in_valid = 1'b1; op = 3'd2; a = 32'h40400000; b = 32'h40400000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst.busy_en", 32'(unit_en), 32'b00100);
    rst_n = 1'b0;
    #1;
    chk("midrst.ctrl", {22'd0, in_ready, out_valid, unit_start, unit_en, status}, 32'b10_0000_0000);
    chk("midrst.result", result, 32'd0);
    chk("midrst.operands", unit_a | unit_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    unit_done = 1'b1; unit_result = 32'hDEADBEEF;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      unit_done = 1'b0;
      if (out_valid || unit_start || !in_ready || unit_en != 5'd0) bad++;
    end
    chk("midrst.late_done", 32'(bad), 32'd0);
    run_op("midrst.sqrt", 3'd4, 32'h41800000, 32'h0, 32'h40800000, 2, 1, 1'b0,
           4, 32'h40800000, 2'b00, 5'b10000);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = $urandom_range(1, 70);
      ur  = $urandom;
      model(rop, rd, ur, lat_e, res_e, st_e, en_e);
      run_op($sformatf("rnd%0d", n), rop, $urandom, $urandom, ur, rd,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat_e, res_e, st_e, en_e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
